// File: rtl/reg_file_dump.sv
// Register file dump engine: walks every address over a synchronous read port
// and streams each captured word with its address on a valid/ready output.
module reg_file_dump #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] RA,
    input  logic [WORD_WIDTH-1:0]    RD,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_addr
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    state_t                   state, state_nx;
    logic [ADDRESS_WIDTH-1:0] addr, addr_nx;
    logic [WORD_WIDTH-1:0]    data_nx;
    logic [ADDRESS_WIDTH-1:0] oaddr_nx;
    logic                     valid_nx;
    logic                     done_nx;

    assign RA   = addr;
    assign busy = (state != IDLE);

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        data_nx  = out_data;
        oaddr_nx = out_addr;
        valid_nx = out_valid;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    addr_nx  = '0;
                    state_nx = READ;
                end
            end
            READ: begin
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                data_nx  = RD;
                oaddr_nx = addr;
                valid_nx = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_nx = 1'b0;
                    if (addr == LAST_ADDR) begin
                        // Park addr at 0 so RA reads 0 while idle.
                        addr_nx  = '0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        addr_nx  = addr + 1'b1;
                        state_nx = READ;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            out_data  <= data_nx;
            out_addr  <= oaddr_nx;
            out_valid <= valid_nx;
            done      <= done_nx;
        end
    end

endmodule
